// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_stream_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int XFER_CNT_W = 16;

  // Skid buffer occupancy; the encoding equals the number of held words.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register skid buffer. Entry 0 is always the head, so the output
// data comes straight from a flop. Push and pop on the same edge are both
// honoured; the caller guarantees no push while two words are held.
module fifo_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output occ_t              o_occ
);

  occ_t              r_occ;
  logic [DATA_W-1:0] r_ent0;
  logic [DATA_W-1:0] r_ent1;

  // Occupancy and entry update: shift entry 1 forward on a pop, write the tail on a push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ  <= S_EMPTY;
      r_ent0 <= '0;
      r_ent1 <= '0;
    end else begin
      case (r_occ)
        S_EMPTY: begin
          if (i_push) begin
            r_ent0 <= i_din;
            r_occ  <= S_ONE;
          end
        end
        S_ONE: begin
          if (i_push && !i_pop) begin
            r_ent1 <= i_din;
            r_occ  <= S_TWO;
          end else if (!i_push && i_pop) begin
            r_occ <= S_EMPTY;
          end else if (i_push && i_pop) begin
            r_ent0 <= i_din;
          end
        end
        S_TWO: begin
          if (i_pop) begin
            r_ent0 <= r_ent1;
            if (i_push) begin
              r_ent1 <= i_din;
            end else begin
              r_occ <= S_ONE;
            end
          end
        end
        default: r_occ <= S_EMPTY;
      endcase
    end
  end

  assign o_head = r_ent0;
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_stream_out.sv
// Read-side adapter: drains a synchronous FIFO (one-cycle read latency) into
// a registered valid/ready stream. A read is issued only when the skid buffer
// has room for every word already committed, counting the one in flight.
// Optional build macro: FIFO_STREAM_STATS_EN adds the saturating xfer_cnt port.
//
// Stream handshake: a beat transfers on a rising edge where m_valid and
// m_ready are both high; m_valid/m_data come from flops and, once m_valid is
// high, stay unchanged until that beat is accepted.
module fifo_stream_out
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_W-1:0]     fifo_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     m_data
`ifdef FIFO_STREAM_STATS_EN
  ,
  output logic [XFER_CNT_W-1:0] xfer_cnt
`endif
);

  logic              r_inflight;
  occ_t              w_occ;
  logic              w_pop;
  logic [2:0]        w_credit_use;
  logic [DATA_W-1:0] w_head;

  assign w_pop        = m_valid && m_ready;
  // Words held after this edge if no new read were issued now.
  assign w_credit_use = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  // Reset gates the strobe so it drops immediately, not at the next edge.
  assign fifo_rd      = rst && !fifo_empty && (w_credit_use < 3'd2);

  // A word issued this cycle appears on fifo_dout next cycle and is pushed then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd;
    end
  end

  fifo_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_inflight),
    .i_din  (fifo_dout),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_occ  (w_occ)
  );

  assign m_valid = (w_occ != S_EMPTY);
  assign m_data  = w_head;

`ifdef FIFO_STREAM_STATS_EN
  logic [XFER_CNT_W-1:0] r_xfer_cnt;

  // Accepted-beat counter, saturating at all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xfer_cnt <= '0;
    end else if (w_pop && (r_xfer_cnt != {XFER_CNT_W{1'b1}})) begin
      r_xfer_cnt <= r_xfer_cnt + 1'b1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// Testbench for fifo_stream_out. Models the upstream FIFO with a queue and
// checks the output stream against the sequence of words written into it.
module tb_fifo_stream_out;
  import fifo_stream_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         fifo_empty = 1'b1;
  logic         fifo_rd;
  logic [W-1:0] fifo_dout = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
`ifdef FIFO_STREAM_STATS_EN
  logic [15:0]  xfer_cnt;
`endif

  fifo_stream_out #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_STREAM_STATS_EN
    ,
    .xfer_cnt   (xfer_cnt)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  // bookkeeping
  int           n_checks = 0;
  int           n_err    = 0;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_cnt = '0;
  logic         rd_take = 1'b0;
  logic         cur_rd, cur_valid, cur_pop;
  logic [W-1:0] cur_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_cnt(input string name);
`ifdef FIFO_STREAM_STATS_EN
    chk(name, {16'h0, xfer_cnt}, {16'h0, exp_cnt});
`endif
  endtask

  // driver: write one word into the modelled FIFO
  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // the FIFO shares the adapter's reset, so its model is cleared too
  task automatic reset_model();
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    rd_take    = 1'b0;
    exp_cnt    = '0;
  endtask

  // One clock cycle, entered and left at the falling edge. Samples outputs,
  // runs the scoreboard, then applies the FIFO read contract after the edge.
  task automatic cycle();
    #1;
    cur_rd    = fifo_rd;
    cur_valid = m_valid;
    cur_data  = m_data;
    cur_pop   = m_valid && m_ready;
    chk("rd_while_empty", {31'h0, fifo_rd && fifo_empty}, 32'h0);
    if (cur_pop) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {24'h0, m_data}, 32'hFFFF_FFFF);
      end else begin
        chk("beat_data", {24'h0, m_data}, {24'h0, exp_q.pop_front()});
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
    end
    rd_take = fifo_rd && !fifo_empty;
    @(posedge clk);
    #1;
    if (rd_take && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    m_ready = 1'b1;
    while (exp_q.size() > 0 && n < limit) begin
      cycle();
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
    cycle();
    cycle();
  endtask

  typedef struct {
    logic         push;
    logic [W-1:0] wdata;
    logic         ready;
    logic         exp_rd;
    logic         exp_valid;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t tbl[12];

  // overall time bound
  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    int rd_n, rd_first, rd_last, b_n, b_first, b_last, pushed, n;
    logic [W-1:0] w0;

    // cycle-by-cycle timeline: one word, then three words under stall
    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};

    // reset held with a non-empty FIFO and ready high
    @(negedge clk);
    m_ready = 1'b1;
    push_word(8'h5C);
    push_word(8'h3D);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_fifo_rd", {31'h0, cur_rd}, 32'h0);
      chk("rst_m_valid", {31'h0, cur_valid}, 32'h0);
      chk("rst_m_data", {24'h0, cur_data}, 32'h0);
      chk_cnt("rst_xfer_cnt");
    end
    reset_model();
    rst = 1'b1;

    // table-driven timeline
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].push) push_word(tbl[i].wdata);
      m_ready = tbl[i].ready;
      cycle();
      chk($sformatf("tbl%0d_rd", i), {31'h0, cur_rd}, {31'h0, tbl[i].exp_rd});
      chk($sformatf("tbl%0d_valid", i), {31'h0, cur_valid}, {31'h0, tbl[i].exp_valid});
      if (tbl[i].exp_valid)
        chk($sformatf("tbl%0d_data", i), {24'h0, cur_data}, {24'h0, tbl[i].exp_data});
    end
    chk_cnt("tbl_xfer_cnt");

    // streaming: 16 words back to back
    for (int i = 0; i < 16; i++) push_word(W'(i));
    m_ready = 1'b1;
    rd_n = 0; rd_first = -1; rd_last = -1; b_n = 0; b_first = -1; b_last = -1;
    for (int c = 0; c < 22; c++) begin
      cycle();
      if (cur_rd) begin
        rd_n++;
        if (rd_first < 0) rd_first = c;
        rd_last = c;
      end
      if (cur_pop) begin
        b_n++;
        if (b_first < 0) b_first = c;
        b_last = c;
      end
    end
    chk("stream_rd_count", rd_n, 16);
    chk("stream_rd_run", rd_last - rd_first + 1, 16);
    chk("stream_beats", b_n, 16);
    chk("stream_beat_run", b_last - b_first + 1, 16);
    chk("stream_latency", b_first - rd_first, 2);
    drain(10);
    chk_cnt("stream_xfer_cnt");

    // backpressure: 8 words, stalled, then released
    w0 = W'($urandom_range(0, 255));
    push_word(w0);
    for (int i = 1; i < 8; i++) push_word(W'($urandom_range(0, 255)));
    m_ready = 1'b0;
    rd_n = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (cur_rd) rd_n++;
    end
    chk("bp_rd_count", rd_n, 2);
    chk("bp_valid", {31'h0, cur_valid}, 32'h1);
    chk("bp_data_held", {24'h0, cur_data}, {24'h0, w0});
    m_ready = 1'b1;
    b_n = 0; b_first = -1; b_last = -1;
    for (int c = 0; c < 14; c++) begin
      cycle();
      if (cur_pop) begin
        b_n++;
        if (b_first < 0) b_first = c;
        b_last = c;
      end
    end
    chk("bp_beats", b_n, 8);
    chk("bp_first_beat", b_first, 0);
    chk("bp_no_bubble", b_last - b_first + 1, 8);
    drain(10);
    chk_cnt("bp_xfer_cnt");

    // random writes and random stalls
    pushed = 0;
    n = 0;
    while ((pushed < 30 || exp_q.size() > 0) && n < 800) begin
      if (pushed < 30 && $urandom_range(0, 2) == 0) begin
        push_word(W'($urandom));
        pushed++;
      end
      m_ready = $urandom_range(0, 1) == 1;
      cycle();
      n++;
    end
    chk("rand_pushed", pushed, 30);
    chk("rand_all_delivered", exp_q.size(), 0);
    drain(10);
    chk_cnt("rand_xfer_cnt");

    // asynchronous reset while the skid buffer holds two words
    for (int i = 0; i < 4; i++) push_word(W'(8'hC0 + i));
    m_ready = 1'b0;
    for (int c = 0; c < 4; c++) cycle();
    chk("mid_valid_before", {31'h0, m_valid}, 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, m_valid}, 32'h0);
    chk("mid_rst_data", {24'h0, m_data}, 32'h0);
    chk("mid_rst_rd", {31'h0, fifo_rd}, 32'h0);
    reset_model();
    chk_cnt("mid_rst_xfer_cnt");
    m_ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b1;
    push_word(8'h5A);
    b_n = 0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (cur_pop) b_n++;
    end
    chk("post_rst_beats", b_n, 1);
    chk_cnt("post_rst_xfer_cnt");

`ifdef FIFO_STREAM_STATS_EN
    // saturation of the beat counter
    force dut.r_xfer_cnt = 16'hFFFE;
    #1;
    release dut.r_xfer_cnt;
    exp_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) push_word(W'(8'hE0 + i));
    drain(20);
    chk("sat_xfer_cnt", {16'h0, xfer_cnt}, 32'h0000_FFFF);
    chk_cnt("sat_model_cnt");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
